serial_loader: RTL and testbench
================================

SERIAL_LOADER -- requirements
Module: serial_loader

Interface
REQ-001 The module SHALL have parameter D_WIDTH, default 32, meaning memory word width in bits.
REQ-002 The module SHALL have parameter D_DEPTH_WIDTH, default 10, meaning memory address width in words.
REQ-003 The module SHALL have port clk  input  1  system clock; the design uses one clock, and all logic is rising-edge.
REQ-004 The module SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The module SHALL have port bit_in  input  1  serial data bit, LSB first.
REQ-006 The module SHALL have port bit_valid  input  1  bit_in is accepted on this edge.
REQ-007 The module SHALL have port frame_start  input  1  one-cycle pulse that begins a new frame.
REQ-008 The module SHALL have port frame_end  input  1  one-cycle pulse that closes the current frame.
REQ-009 The module SHALL have port mem_en  output  1  memory write strobe.
REQ-010 The module SHALL have port mem_wr_mask  output  4  byte write mask.
REQ-011 The module SHALL have port mem_addr  output  D_DEPTH_WIDTH  word address.
REQ-012 The module SHALL have port mem_data  output  D_WIDTH  write data.
REQ-013 The module SHALL have port cpu_hold  output  1  high while state != IDLE, and drives the core reset during a load.
REQ-014 The module SHALL have port done  output  1  one-cycle pulse on clean frame completion.
REQ-015 The module SHALL have port error  output  1  sticky frame-error flag.
REQ-016 The module SHALL have port word_count  output  D_DEPTH_WIDTH+1  number of words written in the current or last frame.

Function
REQ-017 Frame format SHALL be a 16-bit header followed by zero or more D_WIDTH-bit words; all fields are LSB first.
REQ-018 Header bits [9:0] SHALL give the start word address, bits [13:10] the write mask, and bits [15:14] are reserved and ignored.
REQ-019 States SHALL be IDLE, HEADER and DATA.
REQ-020 IDLE SHALL go to HEADER on frame_start, and frame_start SHALL clear error, word_count and the bit counter.
REQ-021 In HEADER, the 16th accepted bit SHALL load the address and mask registers and move the state to DATA.
REQ-022 In DATA, each accepted bit SHALL shift into an assembly register and increment a 6-bit bit counter that runs 0..31.
REQ-023 On the 32nd bit, the assembled word SHALL be copied into mem_data, the counter SHALL return to 0, and mem_en SHALL be 1 on the next cycle only, so write latency is 1 cycle after the final bit.
REQ-024 mem_addr and mem_wr_mask SHALL be stable while mem_en=1.
REQ-025 mem_addr SHALL increment in the cycle after each write and SHALL wrap modulo 2^D_DEPTH_WIDTH (1023 -> 0).
REQ-026 word_count SHALL increment with each write and SHALL saturate at 2^D_DEPTH_WIDTH.
REQ-027 Bits SHALL be accepted back-to-back every cycle with no stall; the bit arriving in the mem_en cycle SHALL be bit 0 of the next word.
REQ-028 frame_end in DATA with bit counter = 0 SHALL return the state to IDLE and pulse done on the next cycle.
REQ-029 frame_end in HEADER, or in DATA with counter != 0, SHALL discard the partial bits, set error, return to IDLE, and produce no done pulse.
REQ-030 When bit_valid and frame_end occur in the same cycle, the bit SHALL be accepted first and frame_end then evaluated against the updated counter.
REQ-031 frame_start in HEADER or DATA SHALL abort the current frame, set error only if a partial header or word was pending, and restart in HEADER.
REQ-032 Inputs bit_valid and frame_end SHALL be ignored in IDLE.
REQ-033 A header mask of 4'b0000 SHALL still produce mem_en pulses carrying the zero mask.

Reset
REQ-034 When rst=1 the module SHALL set state=IDLE, mem_en=0, mem_wr_mask=0, mem_addr=0, mem_data=0, cpu_hold=0, done=0, error=0, word_count=0 and bit counter=0 on the next edge.
REQ-035 Reset asserted mid-frame SHALL abandon the frame with no write and no done pulse, and SHALL leave error clear.
REQ-036 rst SHALL take priority over frame_start.

Structure
REQ-037 A shared package SHALL hold D_WIDTH, D_DEPTH_WIDTH, the HDR_BITS=16 constant, the header field offsets and the state encoding.
REQ-038 One sub-module SHALL be used, loader_shift_reg: a parameterised LSB-first shift register with bit counter and full flag, reused for both header and data.

Verification
REQ-039 A bench SHALL cover: header addr=0x010 mask=0xF, word 0xDEADBEEF, frame_end -> one mem_en with addr 0x010 and data 0xDEADBEEF, then done; word_count=1; error=0.
REQ-040 A bench SHALL cover: addr=0x3FF, two continuous words 0x11111111 and 0x22222222 -> writes to 0x3FF then 0x000 with no gap in bit acceptance.
REQ-041 A bench SHALL cover: frame_end after 20 data bits -> no write, error=1, no done, cpu_hold drops the next cycle.
REQ-042 A bench SHALL cover: 32nd bit and frame_end in the same cycle -> the write occurs and done pulses.
REQ-043 A bench SHALL cover: frame_start after 8 header bits -> error=1, new header accepted, the following word written at the new address.
REQ-044 A bench SHALL cover: rst during bit 15 of a word -> all outputs 0, no mem_en, and a later frame loads normally.

Source files
------------

// File: rtl/serial_loader_pkg.sv
// rtl/serial_loader_pkg.sv - shared widths, header layout and state encoding for serial_loader
package serial_loader_pkg;
    localparam int D_WIDTH       = 32;
    localparam int D_DEPTH_WIDTH = 10;
    localparam int HDR_BITS      = 16;
    localparam int HDR_ADDR_LSB  = 0;
    localparam int HDR_ADDR_W    = 10;
    localparam int HDR_MASK_LSB  = 10;
    localparam int HDR_MASK_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } state_e;
endpackage

// File: rtl/loader_shift_reg.sv
// rtl/loader_shift_reg.sv - LSB-first shift register with bit counter and full flag
module loader_shift_reg #(
    parameter int W  = 32,
    parameter int CW = $clog2(W) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          shift_en_i,
    input  logic          bit_i,
    output logic [W-1:0]  word_o,
    output logic [CW-1:0] count_o,
    output logic          full_o
);
    // Only W-1 bits are stored; the completing bit is taken straight from bit_i.
    logic [W-2:0]  data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign word_o  = {bit_i, data_q};
    assign count_o = cnt_q;
    assign full_o  = shift_en_i && (cnt_q == CW'(W - 1));

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (shift_en_i) begin
            data_d = word_o[W-1:1];
            cnt_d  = full_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/serial_loader.sv
// rtl/serial_loader.sv - serial frame loader writing header-addressed words into memory
module serial_loader #(
    parameter int D_WIDTH       = serial_loader_pkg::D_WIDTH,
    parameter int D_DEPTH_WIDTH = serial_loader_pkg::D_DEPTH_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    input  logic                     frame_start,
    input  logic                     frame_end,
    output logic                     mem_en,
    output logic [3:0]               mem_wr_mask,
    output logic [D_DEPTH_WIDTH-1:0] mem_addr,
    output logic [D_WIDTH-1:0]       mem_data,
    output logic                     cpu_hold,
    output logic                     done,
    output logic                     error,
    output logic [D_DEPTH_WIDTH:0]   word_count
);
    import serial_loader_pkg::*;

    localparam logic [D_DEPTH_WIDTH:0] WC_MAX = {1'b1, {D_DEPTH_WIDTH{1'b0}}};

    state_e                   state_q;
    logic                     mem_en_q, cpu_hold_q, done_q, error_q;
    logic [3:0]               mem_wr_mask_q;
    logic [D_DEPTH_WIDTH-1:0] mem_addr_q;
    logic [D_WIDTH-1:0]       mem_data_q;
    logic [D_DEPTH_WIDTH:0]   word_count_q;

    logic                     hdr_shift, dat_shift, sr_clr;
    logic [HDR_BITS-1:0]      hdr_word;
    logic [$clog2(HDR_BITS):0] hdr_cnt;
    logic                     hdr_full;
    logic [D_WIDTH-1:0]       dat_word;
    logic [$clog2(D_WIDTH):0] dat_cnt;
    logic                     dat_full;
    logic                     abort_pending, end_partial;
    logic [D_DEPTH_WIDTH-1:0] hdr_addr;
    logic                     unused_hdr_rsvd;

    assign hdr_shift = (state_q == ST_HEADER) && bit_valid && !frame_start;
    assign dat_shift = (state_q == ST_DATA) && bit_valid && !frame_start;
    assign sr_clr    = frame_start || (frame_end && state_q != ST_IDLE);

    // Restart only counts as an error if some header or word bits were already collected.
    assign abort_pending = ((state_q == ST_HEADER) && hdr_cnt != '0) ||
                           ((state_q == ST_DATA) && dat_cnt != '0);
    // frame_end is judged after this cycle's bit has been taken.
    assign end_partial   = (state_q == ST_HEADER) ? !hdr_full :
                           (dat_full ? 1'b0 : (dat_cnt != '0 || dat_shift));

    assign hdr_addr        = D_DEPTH_WIDTH'(hdr_word[HDR_ADDR_LSB +: HDR_ADDR_W]);
    assign unused_hdr_rsvd = ^hdr_word[HDR_BITS-1:HDR_MASK_LSB+HDR_MASK_W];

    loader_shift_reg #(.W(HDR_BITS)) u_hdr_sr (
        .clk_i     (clk),
        .rst_i     (rst),
        .clr_i     (sr_clr),
        .shift_en_i(hdr_shift),
        .bit_i     (bit_in),
        .word_o    (hdr_word),
        .count_o   (hdr_cnt),
        .full_o    (hdr_full)
    );

    loader_shift_reg #(.W(D_WIDTH)) u_dat_sr (
        .clk_i     (clk),
        .rst_i     (rst),
        .clr_i     (sr_clr),
        .shift_en_i(dat_shift),
        .bit_i     (bit_in),
        .word_o    (dat_word),
        .count_o   (dat_cnt),
        .full_o    (dat_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mem_en_q      <= 1'b0;
            mem_wr_mask_q <= '0;
            mem_addr_q    <= '0;
            mem_data_q    <= '0;
            cpu_hold_q    <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            word_count_q  <= '0;
        end else begin
            mem_en_q <= 1'b0;
            done_q   <= 1'b0;
            // Address advances only after the write strobe so it is stable during mem_en.
            if (mem_en_q) begin
                mem_addr_q <= mem_addr_q + 1'b1;
            end
            if (frame_start) begin
                state_q      <= ST_HEADER;
                cpu_hold_q   <= 1'b1;
                error_q      <= abort_pending;
                word_count_q <= '0;
            end else begin
                case (state_q)
                    ST_HEADER: begin
                        if (hdr_full) begin
                            mem_addr_q    <= hdr_addr;
                            mem_wr_mask_q <= hdr_word[HDR_MASK_LSB +: HDR_MASK_W];
                            state_q       <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (dat_full) begin
                            mem_data_q <= dat_word;
                            mem_en_q   <= 1'b1;
                            if (word_count_q != WC_MAX) begin
                                word_count_q <= word_count_q + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
                if (frame_end && state_q != ST_IDLE) begin
                    state_q    <= ST_IDLE;
                    cpu_hold_q <= 1'b0;
                    if (end_partial) begin
                        error_q <= 1'b1;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_wr_mask = mem_wr_mask_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data    = mem_data_q;
    assign cpu_hold    = cpu_hold_q;
    assign done        = done_q;
    assign error       = error_q;
    assign word_count  = word_count_q;
endmodule

// File: tb/tb_serial_loader.sv
// tb/tb_serial_loader.sv - self-checking bench for serial_loader
module tb_serial_loader;
    logic        clk = 1'b0;
    logic        rst, bit_in, bit_valid, frame_start, frame_end;
    logic        mem_en, cpu_hold, done, error;
    logic [3:0]  mem_wr_mask;
    logic [9:0]  mem_addr;
    logic [31:0] mem_data;
    logic [10:0] word_count;

    serial_loader #(.D_WIDTH(32), .D_DEPTH_WIDTH(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .frame_start(frame_start),
        .frame_end  (frame_end),
        .mem_en     (mem_en),
        .mem_wr_mask(mem_wr_mask),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;

    typedef struct {
        logic [9:0]  addr;
        logic [3:0]  mask;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t exp_q[$];
    wr_t act_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_en) act_q.push_back('{mem_addr, mem_wr_mask, mem_data, cyc});
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input bit gappy, input bit fe, output int c);
        if (gappy && $urandom_range(3) == 0) begin
            bit_valid = 1'b0;
            tick();
        end
        bit_valid = 1'b1;
        bit_in    = b;
        frame_end = fe;
        c = cyc + 1;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_header(input logic [9:0] addr, input logic [3:0] mask, input bit gappy);
        logic [15:0] hdr;
        int c;
        hdr = {2'($urandom), mask, addr};
        for (int i = 0; i < 16; i++) send_bit(hdr[i], gappy, 1'b0, c);
    endtask

    task automatic send_word(input logic [31:0] w, input int addr, input logic [3:0] mask,
                             input bit gappy, input bit fe_last);
        int c;
        for (int i = 0; i < 32; i++) send_bit(w[i], gappy, fe_last && i == 31, c);
        exp_q.push_back('{10'(addr % 1024), mask, w, c});
    endtask

    task automatic check_writes(input string name, input int ab, input int eb);
        int n_act, n_exp;
        n_act = act_q.size() - ab;
        n_exp = exp_q.size() - eb;
        chk({name, ".nwrites"}, n_act, n_exp);
        for (int k = 0; k < n_act && k < n_exp; k++) begin
            chk({name, ".addr"}, act_q[ab+k].addr, exp_q[eb+k].addr);
            chk({name, ".mask"}, act_q[ab+k].mask, exp_q[eb+k].mask);
            chk({name, ".data"}, act_q[ab+k].data, exp_q[eb+k].data);
            chk({name, ".latency"}, act_q[ab+k].cyc, exp_q[eb+k].cyc);
        end
    endtask

    task automatic run_frame(input string name, input logic [9:0] addr, input logic [3:0] mask,
                             input int nw, input logic [31:0] ws[4], input int tail,
                             input bit fe_last, input bit gappy,
                             input bit exp_err, input bit exp_done, input int exp_wc);
        int ab, eb, db, c;
        ab = act_q.size();
        eb = exp_q.size();
        db = done_cnt;
        start_frame();
        send_header(addr, mask, gappy);
        chk({name, ".hold"}, cpu_hold, 1);
        for (int k = 0; k < nw; k++)
            send_word(ws[k], int'(addr) + k, mask, gappy, fe_last && k == nw - 1);
        for (int i = 0; i < tail; i++) send_bit(1'($urandom), gappy, 1'b0, c);
        if (!(fe_last && nw > 0)) begin
            frame_end = 1'b1;
            tick();
            frame_end = 1'b0;
        end
        chk({name, ".hold_drop"}, cpu_hold, 0);
        chk({name, ".done_now"}, done, exp_done);
        tick();
        tick();
        check_writes(name, ab, eb);
        chk({name, ".done_cnt"}, done_cnt - db, exp_done);
        chk({name, ".error"}, error, exp_err);
        chk({name, ".word_count"}, word_count, exp_wc);
    endtask

    typedef struct {
        logic [9:0]  addr;
        logic [3:0]  mask;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
        int          tail;
        bit          fe_last;
        bit          exp_err;
        bit          exp_done;
        int          exp_wc;
    } vec_t;

    vec_t vt[7];

    initial begin
        logic [31:0] ws[4];
        int ab, db, c;

        vt[0] = '{10'h010, 4'hF, 1, 32'hDEADBEEF, 32'h0,        0,  1'b0, 1'b0, 1'b1, 1};
        vt[1] = '{10'h3FF, 4'h5, 2, 32'h11111111, 32'h22222222, 0,  1'b0, 1'b0, 1'b1, 2};
        vt[2] = '{10'h123, 4'h0, 1, 32'hA5A50F0F, 32'h0,        0,  1'b0, 1'b0, 1'b1, 1};
        vt[3] = '{10'h020, 4'hF, 0, 32'h0,        32'h0,        20, 1'b0, 1'b1, 1'b0, 0};
        vt[4] = '{10'h055, 4'h3, 1, 32'hCAFEF00D, 32'h0,        5,  1'b0, 1'b1, 1'b0, 1};
        vt[5] = '{10'h200, 4'hA, 1, 32'h12345678, 32'h0,        0,  1'b1, 1'b0, 1'b1, 1};
        vt[6] = '{10'h000, 4'hF, 0, 32'h0,        32'h0,        0,  1'b0, 1'b0, 1'b1, 0};

        rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
        repeat (3) tick();
        chk("reset.mem_en", mem_en, 0);
        chk("reset.addr", mem_addr, 0);
        chk("reset.hold", cpu_hold, 0);
        chk("reset.error", error, 0);
        chk("reset.word_count", word_count, 0);
        rst = 1'b0;

        // Stray bits and frame_end while idle must do nothing
        db = done_cnt;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1; bit_in = 1'b1; frame_end = (i == 2);
            tick();
        end
        bit_valid = 1'b0; frame_end = 1'b0;
        tick();
        chk("idle.hold", cpu_hold, 0);
        chk("idle.error", error, 0);
        chk("idle.done", done_cnt - db, 0);
        chk("idle.nwrites", act_q.size(), 0);

        for (int v = 0; v < 7; v++) begin
            ws[0] = vt[v].w0; ws[1] = vt[v].w1; ws[2] = 32'h0; ws[3] = 32'h0;
            run_frame($sformatf("vec%0d", v), vt[v].addr, vt[v].mask, vt[v].nw, ws,
                      vt[v].tail, vt[v].fe_last, 1'b0,
                      vt[v].exp_err, vt[v].exp_done, vt[v].exp_wc);
        end

        // Restart after 8 header bits: error, then the new header is used
        ab = act_q.size();
        c = exp_q.size();
        db = done_cnt;
        start_frame();
        for (int i = 0; i < 8; i++) begin
            int cc;
            send_bit(1'b1, 1'b0, 1'b0, cc);
        end
        start_frame();
        chk("restart.error", error, 1);
        chk("restart.hold", cpu_hold, 1);
        send_header(10'h2A0, 4'h6, 1'b0);
        send_word(32'h0BADF00D, 'h2A0, 4'h6, 1'b0, 1'b0);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        tick();
        tick();
        check_writes("restart", ab, c);
        chk("restart.done", done_cnt - db, 1);
        chk("restart.word_count", word_count, 1);

        // Reset in the middle of a word
        ab = act_q.size();
        db = done_cnt;
        start_frame();
        send_header(10'h0F0, 4'hF, 1'b0);
        for (int i = 0; i < 15; i++) begin
            int cc;
            send_bit(1'($urandom), 1'b0, 1'b0, cc);
        end
        rst = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        rst = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        chk("rst.mem_en", mem_en, 0);
        chk("rst.mask", mem_wr_mask, 0);
        chk("rst.addr", mem_addr, 0);
        chk("rst.data", mem_data, 0);
        chk("rst.hold", cpu_hold, 0);
        chk("rst.done", done, 0);
        chk("rst.error", error, 0);
        chk("rst.word_count", word_count, 0);
        repeat (40) tick();
        chk("rst.nwrites", act_q.size() - ab, 0);
        chk("rst.no_done", done_cnt - db, 0);
        ws[0] = 32'h600DCAFE; ws[1] = 32'h0; ws[2] = 32'h0; ws[3] = 32'h0;
        run_frame("post_rst", 10'h1C4, 4'h9, 1, ws, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1);

        // Random frames against the frame-level model
        for (int f = 0; f < 25; f++) begin
            logic [9:0] a;
            logic [3:0] m;
            int nw, tail;
            bit fe_last, gappy, e_err;
            a = ($urandom_range(2) == 0) ? 10'($urandom_range(1023, 1020)) : 10'($urandom);
            m = 4'($urandom);
            nw = $urandom_range(3);
            for (int k = 0; k < 4; k++) ws[k] = $urandom;
            tail = ($urandom_range(1) == 0) ? 0 : $urandom_range(31, 1);
            fe_last = (tail == 0) && (nw > 0) && ($urandom_range(1) == 1);
            gappy = ($urandom_range(1) == 1);
            e_err = (tail != 0);
            run_frame($sformatf("rnd%0d", f), a, m, nw, ws, tail, fe_last, gappy,
                      e_err, !e_err, nw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
